// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester regfile write-port arbiter with busy scoreboard; ROUND_ROBIN_EN selects alternating priority
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  claim_valid,
  input  logic [ADDR_W-1:0]     claim_reg,
  input  logic                  a_req,
  input  logic [ADDR_W-1:0]     a_dest,
  input  logic [DATA_W-1:0]     a_data,
  output logic                  a_gnt,
  input  logic                  b_req,
  input  logic [ADDR_W-1:0]     b_dest,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  b_gnt,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_dest,
  output logic [DATA_W-1:0]     wr_data,
  output logic [2**ADDR_W-1:0]  busy
);

  localparam int NREGS = 2**ADDR_W;

  logic              x_valid;
  logic [ADDR_W-1:0] x_dest;
  logic [DATA_W-1:0] x_data;
  logic [NREGS-1:0]  busy_next;

`ifdef ROUND_ROBIN_EN
  typedef enum logic {PRI_A, PRI_B} pri_t;
  pri_t ptr, ptr_next;

  // Priority pointer register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr <= PRI_A;
    else        ptr <= ptr_next;
  end

  // Grants from requests and pointer; the side that just transferred yields priority
  always_comb begin
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    ptr_next = ptr;
    if (reset) begin
      if (a_req && (!b_req || ptr == PRI_A)) a_gnt = 1'b1;
      else if (b_req)                        b_gnt = 1'b1;
    end
    if (a_gnt)      ptr_next = PRI_B;
    else if (b_gnt) ptr_next = PRI_A;
  end
`else
  // Fixed priority: A always wins, B only when A is idle
  always_comb begin
    a_gnt = reset & a_req;
    b_gnt = reset & b_req & ~a_req;
  end
`endif

  // Select the transferring requester's destination and data
  always_comb begin
    x_valid = a_gnt | b_gnt;
    x_dest  = a_gnt ? a_dest : b_dest;
    x_data  = a_gnt ? a_data : b_data;
  end

  // Register the winning write; R0 writes are swallowed and outputs hold
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_dest <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= x_valid && (x_dest != '0);
      if (x_valid && (x_dest != '0)) begin
        wr_dest <= x_dest;
        wr_data <= x_data;
      end
    end
  end

  // Scoreboard next state: clear on transfer, then set on claim so a new producer wins
  always_comb begin
    busy_next = busy;
    if (x_valid)     busy_next[x_dest]    = 1'b0;
    if (claim_valid) busy_next[claim_reg] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_next;
  end

endmodule
